// File: rtl/spi_master_ctrl.sv
// Single-word SPI master: programmable CS setup/hold, SCLK divider, CPOL/CPHA and bit order.
// Chained words to the same slave keep CS low; a slave change inserts hold, gap and new setup.
//   state | meaning
//   IDLE  | CS released, waiting for a command
//   SETUP | CS low, first bit on mosi, setup delay running
//   SHIFT | 2*DATA_WIDTH SCLK edges
//   HOLD  | CS still low after the last edge, hold delay running
//   GAP   | one cycle with every CS high
//   CHAIN | CS kept low, waiting for the next word
module spi_master_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SLAVES = 4,
   parameter int DIV_WIDTH  = 8,
   parameter int DLY_WIDTH  = 4,
   localparam int SS_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_cpol,
   input  logic                  cfg_cpha,
   input  logic                  cfg_lsb_first,
   input  logic [DIV_WIDTH-1:0]  cfg_baud_div,
   input  logic [DLY_WIDTH-1:0]  cfg_cs_setup,
   input  logic [DLY_WIDTH-1:0]  cfg_cs_hold,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic [SS_W-1:0]       cmd_ss,
   input  logic                  cmd_last,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic [NUM_SLAVES-1:0] cs_n,
   output logic                  busy
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, CHAIN} state_t;

   localparam int EC_W = $clog2(2 * DATA_WIDTH + 1);
   localparam logic [EC_W-1:0] EDGES = EC_W'(2 * DATA_WIDTH);

   state_t                state;
   logic                  rdy_en, cpol_r, cpha_r, lsb_r, last_r, pend;
   logic [DIV_WIDTH-1:0]  div_r, div_cnt;
   logic [DLY_WIDTH-1:0]  setup_r, hold_r, dly_cnt;
   logic [SS_W-1:0]       ss_r;
   logic [DATA_WIDTH-1:0] tx_sr, rx_sr, tx_shift, rx_next;
   logic [EC_W-1:0]       edge_cnt;
   logic                  accept, edge_now, odd_edge, final_edge, sample_now;

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_WIDTH-1];
   endfunction

   // Out-of-range slave index decodes to all CS high.
   function automatic logic [NUM_SLAVES-1:0] cs_decode(input logic [SS_W-1:0] s);
      logic [NUM_SLAVES-1:0] r;
      r = '1;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (s == SS_W'(i)) r[i] = 1'b0;
      return r;
   endfunction

   function automatic logic [DLY_WIDTH-1:0] dly_load(input logic [DLY_WIDTH-1:0] d);
      return (d == '0) ? '0 : d - DLY_WIDTH'(1);
   endfunction

   assign cmd_ready  = rdy_en && (state == IDLE || state == CHAIN) && (!rsp_valid || rsp_ready);
   assign accept     = cmd_valid && cmd_ready;
   assign busy       = (state != IDLE);
   assign edge_now   = (state == SHIFT) && (div_cnt == '0);
   assign odd_edge   = ~edge_cnt[0];
   assign final_edge = (edge_cnt == EC_W'(1));
   assign sample_now = edge_now && (odd_edge ^ cpha_r);
   assign tx_shift   = lsb_r ? (tx_sr >> 1) : (tx_sr << 1);
   assign rx_next    = !sample_now ? rx_sr :
                       lsb_r ? {miso, rx_sr[DATA_WIDTH-1:1]} : {rx_sr[DATA_WIDTH-2:0], miso};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rdy_en    <= 1'b0;
         cpol_r    <= 1'b0;
         cpha_r    <= 1'b0;
         lsb_r     <= 1'b0;
         last_r    <= 1'b0;
         pend      <= 1'b0;
         div_r     <= '0;
         div_cnt   <= '0;
         setup_r   <= '0;
         hold_r    <= '0;
         dly_cnt   <= '0;
         ss_r      <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         edge_cnt  <= '0;
         sclk      <= 1'b0;
         mosi      <= 1'b0;
         cs_n      <= '1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
         if (accept) begin
            cpol_r  <= cfg_cpol;
            cpha_r  <= cfg_cpha;
            lsb_r   <= cfg_lsb_first;
            div_r   <= cfg_baud_div;
            setup_r <= cfg_cs_setup;
            hold_r  <= cfg_cs_hold;
            tx_sr   <= cmd_data;
            ss_r    <= cmd_ss;
            last_r  <= cmd_last;
         end
         case (state)
            IDLE: begin
               sclk <= cfg_cpol;
               if (accept) begin
                  cs_n    <= cs_decode(cmd_ss);
                  mosi    <= first_bit(cmd_data, cfg_lsb_first);
                  dly_cnt <= dly_load(cfg_cs_setup);
                  state   <= SETUP;
               end
            end
            SETUP: begin
               if (dly_cnt == '0) begin
                  div_cnt  <= div_r;
                  edge_cnt <= EDGES;
                  state    <= SHIFT;
               end else begin
                  dly_cnt <= dly_cnt - DLY_WIDTH'(1);
               end
            end
            SHIFT: begin
               if (div_cnt == '0) begin
                  div_cnt  <= div_r;
                  edge_cnt <= edge_cnt - EC_W'(1);
                  sclk     <= ~sclk;
                  rx_sr    <= rx_next;
                  if (odd_edge) begin
                     if (cpha_r) mosi <= first_bit(tx_sr, lsb_r);
                  end else begin
                     tx_sr <= tx_shift;
                     if (!cpha_r && !final_edge) mosi <= first_bit(tx_shift, lsb_r);
                  end
                  if (final_edge) begin
                     rsp_data  <= rx_next;
                     rsp_valid <= 1'b1;
                     if (last_r) begin
                        dly_cnt <= dly_load(hold_r);
                        state   <= HOLD;
                     end else begin
                        state <= CHAIN;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt - DIV_WIDTH'(1);
               end
            end
            HOLD: begin
               if (dly_cnt == '0) begin
                  cs_n  <= '1;
                  state <= GAP;
               end else begin
                  dly_cnt <= dly_cnt - DLY_WIDTH'(1);
               end
            end
            GAP: begin
               // A slave switch from CHAIN parks its command here until CS has been high a cycle.
               if (pend) begin
                  pend    <= 1'b0;
                  cs_n    <= cs_decode(ss_r);
                  mosi    <= first_bit(tx_sr, lsb_r);
                  sclk    <= cpol_r;
                  dly_cnt <= dly_load(setup_r);
                  state   <= SETUP;
               end else begin
                  state <= IDLE;
               end
            end
            CHAIN: begin
               sclk <= cfg_cpol;
               if (accept) begin
                  if (cmd_ss == ss_r) begin
                     mosi     <= first_bit(cmd_data, cfg_lsb_first);
                     div_cnt  <= cfg_baud_div;
                     edge_cnt <= EDGES;
                     state    <= SHIFT;
                  end else begin
                     pend    <= 1'b1;
                     dly_cnt <= dly_load(hold_r);
                     state   <= HOLD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: directed transfers, expected words queued at accept.
// Waveform-shape properties (CS timing, SCLK spacing, one-hot CS) come from a cycle monitor.
module tb_spi_master_ctrl;
   localparam int DW = 8, NS = 4, DIVW = 8, DLYW = 4, SSW = 2;

   logic            clk = 1'b0, rst;
   logic            cfg_cpol, cfg_cpha, cfg_lsb_first;
   logic [DIVW-1:0] cfg_baud_div;
   logic [DLYW-1:0] cfg_cs_setup, cfg_cs_hold;
   logic            cmd_valid, cmd_ready, cmd_last;
   logic [DW-1:0]   cmd_data;
   logic [SSW-1:0]  cmd_ss;
   logic            rsp_valid, rsp_ready;
   logic [DW-1:0]   rsp_data;
   logic            sclk, mosi, miso, busy;
   logic [NS-1:0]   cs_n;

   logic            loop_back = 1'b1;
   logic            slv_miso = 1'b0, slv_prev_sclk = 1'b0;
   logic [DW-1:0]   slv_word = '0, slv_rx = '0;
   logic [2:0]      slv_idx = '0;

   int              n_checks = 0, n_fail = 0, n_pop = 0, cyc = 0;
   int              acc_cyc = -1, rsp_hs_cyc = -2;
   logic [DW-1:0]   sb_q[$];

   int              clr_req = 0, clr_seen = 0;
   int              low_cnt[NS], rise_cnt[NS];
   int              tog = 0, gap_min = 0, gap_max = 0, last_tog = 0, mosi_bad = 0;
   int              rel0_cyc = 0, low3_cyc = 0;
   logic [NS-1:0]   low_mask = '0, prev_cs = '1;
   logic            prev_sclk = 1'b0, prev_mosi = 1'b0, overlap_any = 1'b0;

   assign miso = loop_back ? mosi : slv_miso;

   spi_master_ctrl #(.DATA_WIDTH(DW), .NUM_SLAVES(NS), .DIV_WIDTH(DIVW), .DLY_WIDTH(DLYW)) dut (
      .clk(clk), .rst(rst), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first),
      .cfg_baud_div(cfg_baud_div), .cfg_cs_setup(cfg_cs_setup), .cfg_cs_hold(cfg_cs_hold),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_ss(cmd_ss),
      .cmd_last(cmd_last), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n), .busy(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Mode-3 slave on cs_n[2]: drives on falling (leading) edges, captures on rising edges.
   always @(sclk, cs_n[2]) begin
      if (cs_n[2]) slv_idx = '0;
      else if (sclk !== slv_prev_sclk) begin
         if (!sclk) begin
            slv_miso = slv_word[slv_idx];
            slv_idx  = slv_idx + 3'd1;
         end else begin
            slv_rx = {mosi, slv_rx[DW-1:1]};
         end
      end
      slv_prev_sclk = sclk;
   end

   always begin
      @(negedge clk);
      #2;
      if (rst) sb_q.delete();
      else if (rsp_valid && rsp_ready) begin
         rsp_hs_cyc = cyc;
         n_pop++;
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got 0x%0h, expected no response", rsp_data);
         end else begin
            check("rsp_data", {24'd0, rsp_data}, {24'd0, sb_q.pop_front()});
         end
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (clr_seen != clr_req) begin
         for (int i = 0; i < NS; i++) begin
            low_cnt[i]  = 0;
            rise_cnt[i] = 0;
         end
         tog = 0; gap_min = 1000; gap_max = 0; mosi_bad = 0; low_mask = '0;
         rel0_cyc = -100; low3_cyc = -200;
         clr_seen = clr_req;
      end
      for (int i = 0; i < NS; i++) begin
         if (!cs_n[i]) low_cnt[i]++;
         if (cs_n[i] && !prev_cs[i]) rise_cnt[i]++;
      end
      low_mask = low_mask | ~cs_n;
      if ($countones(~cs_n) > 1) overlap_any = 1'b1;
      if (sclk != prev_sclk) begin
         if (tog > 0) begin
            if (cyc - last_tog < gap_min) gap_min = cyc - last_tog;
            if (cyc - last_tog > gap_max) gap_max = cyc - last_tog;
         end
         tog++;
         last_tog = cyc;
         if (sclk && mosi != prev_mosi) mosi_bad++;
      end
      if (!prev_cs[0] && cs_n[0]) rel0_cyc = cyc;
      if (prev_cs[3] && !cs_n[3]) low3_cyc = cyc;
      prev_cs = cs_n; prev_sclk = sclk; prev_mosi = mosi;
   end

   task automatic clr_stats();
      clr_req++;
      @(negedge clk);
   endtask

   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic send(input logic [DW-1:0] d, input logic [SSW-1:0] ss, input logic last,
                       input logic [DW-1:0] exp);
      int t;
      logic ok;
      cmd_valid = 1'b1; cmd_data = d; cmd_ss = ss; cmd_last = last;
      t = 0;
      forever begin
         #1;
         ok = cmd_ready;
         acc_cyc = cyc;
         @(posedge clk);
         if (ok) break;
         t++;
         if (t > 3000) break;
         @(negedge clk);
      end
      if (ok) sb_q.push_back(exp);
      else begin
         n_checks++;
         n_fail++;
         $display("FAIL cmd_accept_timeout: cmd_ready stayed 0, expected 1");
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         #3;
         t++;
      end while ((busy || sb_q.size() != 0) && t < 3000);
      n_checks++;
      if (t >= 3000) begin
         n_fail++;
         $display("FAIL %s_timeout: busy=%0b pending=%0d, expected idle and drained", name, busy, sb_q.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst = 1'b1;
      cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0;
      cfg_baud_div = 8'd1; cfg_cs_setup = 4'd2; cfg_cs_hold = 4'd1;
      cmd_valid = 1'b0; cmd_data = '0; cmd_ss = '0; cmd_last = 1'b1; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_cs_n", {28'd0, cs_n}, 32'hF);
      check("rst_outs", {27'd0, sclk, mosi, cmd_ready, rsp_valid, busy}, 32'd0);
      check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
      cfg_cpol = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready_sclk", {30'd0, cmd_ready, sclk}, 32'd3);
      cfg_cpol = 1'b0;
      repeat (2) @(negedge clk);

      // Mode 0, MSB first, loopback.
      clr_stats();
      send(8'hA5, 2'd0, 1'b1, 8'hA5);
      wait_idle("mode0");
      check("mode0_cs0_low_cycles", low_cnt[0], 35);
      check("mode0_cs_mask", {28'd0, low_mask}, 32'h1);
      check("mode0_sclk_edges", tog, 16);
      check("mode0_edge_gap_min", gap_min, 2);
      check("mode0_edge_gap_max", gap_max, 2);
      check("mode0_sclk_idle", {31'd0, sclk}, 32'd0);

      // Mode 3, LSB first, div 0, slave model on slave 2.
      cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_lsb_first = 1'b1; cfg_baud_div = 8'd0;
      loop_back = 1'b0; slv_word = 8'h96;
      repeat (2) @(negedge clk);
      clr_stats();
      send(8'h3C, 2'd2, 1'b1, 8'h96);
      wait_idle("mode3");
      check("mode3_cs_mask", {28'd0, low_mask}, 32'h4);
      check("mode3_slave_rx", {24'd0, slv_rx}, 32'h3C);
      check("mode3_mosi_on_rising", mosi_bad, 0);
      check("mode3_sclk_edges", tog, 16);
      check("mode3_edge_gap_max", gap_max, 1);
      check("mode3_sclk_idle", {31'd0, sclk}, 32'd1);
      cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_baud_div = 8'd1;
      loop_back = 1'b1;
      repeat (2) @(negedge clk);

      // Chain to the same slave: CS stays low, no setup before word 2.
      clr_stats();
      send(8'h11, 2'd1, 1'b0, 8'h11);
      send(8'h22, 2'd1, 1'b1, 8'h22);
      wait_idle("chain");
      check("chain_cs1_low_cycles", low_cnt[1], 68);
      check("chain_cs1_releases", rise_cnt[1], 1);

      // Chain with slave switch: hold on slave 0, one gap cycle, setup on slave 3.
      clr_stats();
      send(8'h55, 2'd0, 1'b0, 8'h55);
      send(8'h66, 2'd3, 1'b1, 8'h66);
      wait_idle("switch");
      check("switch_cs0_low_cycles", low_cnt[0], 36);
      check("switch_cs3_low_cycles", low_cnt[3], 35);
      check("switch_gap_cycles", low3_cyc - rel0_cyc, 1);
      check("switch_cs_mask", {28'd0, low_mask}, 32'h9);

      // Response backpressure.
      rsp_ready = 1'b0;
      clr_stats();
      send(8'hC3, 2'd0, 1'b1, 8'hC3);
      t = 0;
      while (!(rsp_valid && !busy) && t < 500) begin
         @(negedge clk);
         #3;
         t++;
      end
      check("bp_wait_done", {31'd0, t < 500}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #3;
         check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         check("bp_rsp_data", {24'd0, rsp_data}, 32'hC3);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      send(8'h3A, 2'd0, 1'b1, 8'h3A);
      check("bp_accept_same_cycle", acc_cyc - rsp_hs_cyc, 0);
      wait_idle("bp");

      // Reset in the middle of SHIFT.
      clr_stats();
      send(8'h0F, 2'd0, 1'b1, 8'h0F);
      t = 0;
      while (tog < 6 && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("rst_mid_reached_shift", {31'd0, t < 500}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_outs", {25'd0, cs_n, sclk, rsp_valid, busy}, {25'd0, 4'hF, 3'b000});
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(8'hF0, 2'd0, 1'b1, 8'hF0);
      wait_idle("after_rst");

      check("responses_seen", n_pop, 9);
      check("scoreboard_empty", sb_q.size(), 0);
      check("cs_one_hot", {31'd0, overlap_any}, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Synchronous SPI master controller that sequences single-word SPI transfers on the shared SPI bus, serving the same interface the master/slave agent BFMs drive.
- Accepts commands over a valid/ready interface, selects one of NUM_SLAVES chip-selects and applies programmable CS setup/hold delays, SCLK divider, CPOL/CPHA and bit order.
- Returns the captured MISO word over a valid/ready response interface.
- Supports chained transfers that keep CS asserted between words.

Parameters:
- DATA_WIDTH, 8, bits per transfer word.
- NUM_SLAVES, 4, number of chip-select lines; SS_W = max(1, $clog2(NUM_SLAVES)).
- DIV_WIDTH, 8, width of baud divider.
- DLY_WIDTH, 4, width of CS setup/hold counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cfg_cpol  in  1  SCLK idle level.
- cfg_cpha  in  1  0: sample leading edge; 1: sample trailing edge.
- cfg_lsb_first  in  1  bit order.
- cfg_baud_div  in  DIV_WIDTH  SCLK half-period = cfg_baud_div+1 clk.
- cfg_cs_setup  in  DLY_WIDTH  clk cycles from CS low to first SCLK half-period start.
- cfg_cs_hold  in  DLY_WIDTH  clk cycles from last SCLK edge to CS high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_data  in  DATA_WIDTH  MOSI word.
- cmd_ss  in  SS_W  slave index.
- cmd_last  in  1  1: release CS after word; 0: keep CS (chain).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_WIDTH  captured MISO word.
- sclk  out  1  SPI clock.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- cs_n  out  NUM_SLAVES  active-low chip selects.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state): sclk=0, mosi=0, cs_n=all 1, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, state=IDLE. First clk after deassert: cmd_ready=1, sclk=cfg_cpol.
- All cfg_* values are latched at command accept. In IDLE/CHAIN, sclk tracks cfg_cpol each cycle. Changes mid-transfer are ignored.
- cmd_ready = (state IDLE or CHAIN) and (!rsp_valid or rsp_ready).
- States:
  - IDLE: on accept with cmd_ss < NUM_SLAVES, latch command and go to SETUP. An out-of-range cmd_ss is accepted; the controller completes the shift with all cs_n high.
  - SETUP: cs_n[ss]=0 from the cycle after accept. mosi = first bit (MSB, or LSB if lsb_first) for both CPHA values. Stay cfg_cs_setup cycles (0 means exactly 1 cycle), then go to SHIFT.
  - SHIFT: 2*DATA_WIDTH SCLK edges, each edge after cfg_baud_div+1 clk. Edge 1 is leading.
    - CPHA=0: sample miso on odd edges; drive next mosi bit on even edges, except the final edge.
    - CPHA=1: drive mosi on odd edges; sample on even edges.
    - Final edge returns sclk to CPOL.
    - Next cycle: rsp_data = shifted word, assembled in the configured bit order; rsp_valid=1. Go to HOLD if last, else CHAIN.
  - HOLD: cs_n held low cfg_cs_hold cycles (0 means 1 cycle). Then cs_n all high and go to GAP.
  - GAP: exactly 1 cycle with all CS high, then IDLE. This guarantees minimum CS-deassert time.
  - CHAIN: CS stays low and cmd_ready is asserted.
    - Same cmd_ss accepted: go directly to SHIFT; mosi gets the new first bit in the accept+1 cycle, and no setup delay is applied.
    - Different cmd_ss accepted: HOLD on the old slave, GAP, then SETUP on the new slave.
- rsp_valid stays high until rsp_ready. If a new response is due while rsp_valid and !rsp_ready, this cannot occur because cmd_ready is gated.
- Simultaneous rsp_ready and cmd accept in the same cycle is legal.
- Bit counter and divider wrap cleanly. cfg_baud_div=max gives a half-period of 2^DIV_WIDTH clk.
- Only one cs_n bit is ever low at a time.

Test Plan:
- Mode 0, MSB first, div=1, setup=2, hold=1, cmd_data=0xA5, cmd_last=1, miso looped to mosi -> cs_n[0] low for 2+32+1 cycles, 16 sclk edges 2 clk apart, rsp_data=0xA5, cs_n high ≥1 cycle before next accept.
- Mode 3 (cpol=1, cpha=1), lsb_first, div=0, slave 2, cmd_data=0x3C, miso driven by a slave model returning 0x96 -> sclk idles high, data changes on falling edges, rsp_data=0x96, only cs_n[2] toggles.
- Chain: 0x11 (last=0) then 0x22 (last=1), both to slave 1 -> cs_n[1] stays low continuously, no setup cycles before word 2, two responses 0x11/0x22 in order under loopback.
- Chain slave switch: 0x55 to slave 0 (last=0), then 0x66 to slave 3 -> cs_n[0] released after hold, 1-cycle gap, cs_n[3] asserted after setup, never overlapping.
- Backpressure: rsp_ready=0 after first transfer -> rsp_valid held, rsp_data stable, cmd_ready=0. Raise rsp_ready -> next command accepted the same cycle.
- Assert rst during SHIFT at bit 3 -> same cycle: cs_n=all 1, sclk=0, rsp_valid=0, busy=0. After release, a 0xF0 transfer completes correctly.
